// File: rtl/cond_stack_unit.sv
// Condition-evaluation unit with architectural NZCV flags and a small
// save/restore stack used on exception entry and return.
// Instruction requests are gated by the evaluated condition. Flags are
// written from one selected source. Push and Pop save and restore whole
// flag words.
module cond_stack_unit #(
    parameter int NSRC  = 2,
    parameter int DEPTH = 4,
    localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        Cond,
    input  logic [SW-1:0]     FlagSel,
    input  logic [4*NSRC-1:0] SrcFlags,
    input  logic [2*NSRC-1:0] SrcFlagW,
    input  logic              PCS,
    input  logic              RegW,
    input  logic              MemW,
    input  logic              Push,
    input  logic              Pop,
    output logic              PCSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [3:0]        Flags,
    output logic [CW-1:0]     StackCount,
    output logic              StackFull,
    output logic              StackEmpty,
    output logic              StackErr
);

    logic [3:0]    flags_q, flags_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [3:0]    stack_q [DEPTH];
    logic [3:0]    stack_d [DEPTH];

    logic          cond_ex;
    logic [3:0]    src_nzcv;
    logic [1:0]    src_w;
    logic [1:0]    flag_write;
    logic [3:0]    top_val;
    logic          full, empty;
    logic          push_ok, pop_ok, swap, misuse;

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_q;

    // Evaluate the instruction condition against the registered flags.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            default: cond_ex = 1'b1;
        endcase
    end

    assign PCSrc    = PCS  & cond_ex;
    assign RegWrite = RegW & cond_ex;
    assign MemWrite = MemW & cond_ex;

    // Select the flag source. An out-of-range FlagSel matches no source and writes nothing.
    always_comb begin
        src_nzcv = '0;
        src_w    = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (FlagSel == SW'(i)) begin
                src_nzcv = SrcFlags[4*i +: 4];
                src_w    = SrcFlagW[2*i +: 2];
            end
        end
    end

    assign flag_write = src_w & {2{cond_ex}};

    // Read the current top-of-stack entry, at StackCount-1.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CW'(i + 1)) top_val = stack_q[i];
        end
    end

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = Push & ~Pop & ~full;
    assign pop_ok  = Pop & ~Push & ~empty;
    assign swap    = Push & Pop & ~empty;
    assign misuse  = (Push & ~Pop & full) | (Pop & ~Push & empty) | (Push & Pop & empty);

    // Next-state for the flags, the count and the sticky error.
    // A restore from the stack takes priority over a flag write in the same cycle.
    always_comb begin
        flags_d = flags_q;
        if (flag_write[1]) flags_d[3:2] = src_nzcv[3:2];
        if (flag_write[0]) flags_d[1:0] = src_nzcv[1:0];
        if (pop_ok || swap) flags_d = top_val;

        count_d = count_q;
        if (push_ok)     count_d = count_q + CW'(1);
        else if (pop_ok) count_d = count_q - CW'(1);

        err_d = err_q | misuse;
    end

    // Next-state for the stack: push writes entry[count] and swap overwrites the top entry.
    always_comb begin
        stack_d = stack_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && count_q == CW'(i))     stack_d[i] = flags_q;
            if (swap    && count_q == CW'(i + 1)) stack_d[i] = flags_q;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (!reset) begin
            flags_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Stack storage registers, with no reset.
    always_ff @(posedge clk) begin
        // NOTE: stack contents are don't-care after reset because StackCount=0 hides them, so the storage has no reset.
        stack_q <= stack_d;
    end

    assign Flags      = flags_q;
    assign StackCount = count_q;
    assign StackFull  = full;
    assign StackEmpty = empty;
    assign StackErr   = err_q;

endmodule

// File: tb/tb_cond_stack_unit.sv
// Directed bench for cond_stack_unit with default parameters (NSRC=2, DEPTH=4).
// Inputs change 1 time unit after a rising edge. Outputs are checked in the same window.
module tb_cond_stack_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [0:0] FlagSel;
    logic [7:0] SrcFlags;
    logic [3:0] SrcFlagW;
    logic       PCS, RegW, MemW, Push, Pop;
    logic       PCSrc, RegWrite, MemWrite;
    logic [3:0] Flags;
    logic [2:0] StackCount;
    logic       StackFull, StackEmpty, StackErr;

    int n_checks = 0;
    int n_errors = 0;

    cond_stack_unit #(.NSRC(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .FlagSel(FlagSel),
        .SrcFlags(SrcFlags), .SrcFlagW(SrcFlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .Push(Push), .Pop(Pop), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .Flags(Flags),
        .StackCount(StackCount), .StackFull(StackFull),
        .StackEmpty(StackEmpty), .StackErr(StackErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load the flags through source 0 with an always-true condition.
    task automatic load_flags(input logic [3:0] f);
        Cond = 4'b1110; FlagSel = 1'b0; SrcFlags = {4'h0, f}; SrcFlagW = 4'b0011;
        tick();
        SrcFlagW = 4'b0000;
    endtask

    initial begin
        reset = 1'b0; Cond = 4'b0; FlagSel = 1'b0; SrcFlags = 8'h0; SrcFlagW = 4'b0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Push = 1'b0; Pop = 1'b0;
        tick(); tick();
        reset = 1'b1;
        #1;
        check("rst_flags", {4'h0, Flags}, 8'h00);
        check("rst_count", {5'h0, StackCount}, 8'h00);
        check("rst_err", {7'h0, StackErr}, 8'h00);
        check("rst_empty", {7'h0, StackEmpty}, 8'h01);
        check("rst_full", {7'h0, StackFull}, 8'h00);
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
        Cond = 4'b0000; #1;
        check("rst_eq_pcsrc", {7'h0, PCSrc}, 8'h00);
        Cond = 4'b0001; #1;
        check("rst_ne_gates", {5'h0, PCSrc, RegWrite, MemWrite}, 8'h07);
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;

        // Write Z through source 1. The write must not show before the edge.
        Cond = 4'b1110; FlagSel = 1'b1; SrcFlags = 8'h40; SrcFlagW = 4'b1100; #1;
        check("no_bypass", {4'h0, Flags}, 8'h00);
        tick();
        SrcFlagW = 4'b0000;
        check("src1_write", {4'h0, Flags}, 8'h04);
        Cond = 4'b0000; PCS = 1'b1; #1;
        check("eq_taken", {7'h0, PCSrc}, 8'h01);
        PCS = 1'b0;

        // A failed condition blocks both the request and the flag write.
        Cond = 4'b0001; RegW = 1'b1; FlagSel = 1'b0; SrcFlags = 8'h0F; SrcFlagW = 4'b0011; #1;
        check("ne_blocked", {7'h0, RegWrite}, 8'h00);
        tick();
        check("blocked_write", {4'h0, Flags}, 8'h04);
        RegW = 1'b0; SrcFlagW = 4'b0000;

        // A CV-only write leaves NZ unchanged.
        load_flags(4'b1010);
        check("load_1010", {4'h0, Flags}, 8'h0A);
        Cond = 4'b1110; FlagSel = 1'b0; SrcFlags = 8'h05; SrcFlagW = 4'b0001;
        tick();
        SrcFlagW = 4'b0000;
        check("cv_only", {4'h0, Flags}, 8'h09);

        // Signed and unsigned conditions for N=1 Z=0 C=0 V=1.
        PCS = 1'b1;
        Cond = 4'b1010; #1; check("ge", {7'h0, PCSrc}, 8'h01);
        Cond = 4'b1011; #1; check("lt", {7'h0, PCSrc}, 8'h00);
        Cond = 4'b1000; #1; check("hi", {7'h0, PCSrc}, 8'h00);
        Cond = 4'b1001; #1; check("ls", {7'h0, PCSrc}, 8'h01);
        Cond = 4'b1100; #1; check("gt", {7'h0, PCSrc}, 8'h01);
        Cond = 4'b1101; #1; check("le", {7'h0, PCSrc}, 8'h00);
        Cond = 4'b0110; #1; check("vs", {7'h0, PCSrc}, 8'h01);
        PCS = 1'b0;

        // Fill the stack, then overflow it.
        load_flags(4'b0011);
        Push = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("push%0d_count", i), {5'h0, StackCount}, 8'(i));
        end
        check("full_no_err", {6'h0, StackFull, StackErr}, 8'h02);
        tick();
        Push = 1'b0;
        check("ovf_count", {5'h0, StackCount}, 8'h04);
        check("ovf_full_err", {6'h0, StackFull, StackErr}, 8'h03);
        load_flags(4'b1111);
        Pop = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick();
            check($sformatf("pop_count%0d", i), {5'h0, StackCount}, 8'(i));
        end
        Pop = 1'b0;
        check("pop_flags", {4'h0, Flags}, 8'h03);
        check("pop_empty", {7'h0, StackEmpty}, 8'h01);

        // Swap: Push and Pop together exchange the flags and the top entry. The flag write is ignored.
        load_flags(4'b1000);
        Push = 1'b1; tick(); Push = 1'b0;
        load_flags(4'b0001);
        Push = 1'b1; Pop = 1'b1; Cond = 4'b1110; FlagSel = 1'b0; SrcFlags = 8'h0F; SrcFlagW = 4'b0011;
        tick();
        Push = 1'b0; Pop = 1'b0; SrcFlagW = 4'b0000;
        check("swap_flags", {4'h0, Flags}, 8'h08);
        check("swap_count", {5'h0, StackCount}, 8'h01);
        Pop = 1'b1; tick(); Pop = 1'b0;
        check("swap_top", {4'h0, Flags}, 8'h01);

        // A Pop on an empty stack still applies the flag write.
        Pop = 1'b1; Cond = 4'b1110; FlagSel = 1'b0; SrcFlags = 8'h06; SrcFlagW = 4'b0011;
        tick();
        Pop = 1'b0; SrcFlagW = 4'b0000;
        check("underflow_flags", {4'h0, Flags}, 8'h06);
        check("underflow_count", {5'h0, StackCount}, 8'h00);

        // Reset in the middle of a sequence overrides Push.
        Push = 1'b1; tick(); tick();
        check("pre_rst_count", {5'h0, StackCount}, 8'h02);
        check("pre_rst_err", {7'h0, StackErr}, 8'h01);
        reset = 1'b0; tick(); reset = 1'b1; Push = 1'b0;
        check("mid_rst", {StackErr, StackCount, Flags}, 8'h00);

        // A push stores the pre-edge flags while the flag write applies on the same edge.
        Push = 1'b1; Cond = 4'b1110; FlagSel = 1'b1; SrcFlags = 8'hC0; SrcFlagW = 4'b1100;
        tick();
        Push = 1'b0; SrcFlagW = 4'b0000;
        check("push_write_flags", {4'h0, Flags}, 8'h0C);
        Pop = 1'b1; tick(); Pop = 1'b0;
        check("push_saved_old", {4'h0, Flags}, 8'h00);

        // Push and Pop together on an empty stack set the error flag.
        Push = 1'b1; Pop = 1'b1; tick(); Push = 1'b0; Pop = 1'b0;
        check("swap_empty_err", {4'h0, StackErr, StackCount}, 8'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
